// File: rtl/wb_cmd_master_if.sv
// Command, data-stream and Wishbone signals of the matrix-engine bus initiator.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface wb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_we_i;
    logic [ADDR_W-1:0]   cmd_adr_i;
    logic [LEN_W-1:0]    cmd_len_i;
    logic                wdat_valid_i;
    logic [DATA_W-1:0]   wdat_i;
    logic                wdat_ready_o;
    logic                rdat_valid_o;
    logic [DATA_W-1:0]   rdat_o;
    logic                rdat_ready_i;
    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic                wbm_we_o;
    logic [DATA_W/8-1:0] wbm_sel_o;
    logic [ADDR_W-1:0]   wbm_adr_o;
    logic [DATA_W-1:0]   wbm_dat_o;
    logic [DATA_W-1:0]   wbm_dat_i;
    logic                wbm_ack_i;
    logic                wbm_err_i;
    logic                done_o;
    logic                err_o;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i,
        input  wdat_valid_i, wdat_i, rdat_ready_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output done_o, err_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i,
        output wdat_valid_i, wdat_i, rdat_ready_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  done_o, err_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: turns word-burst commands into single-beat cycles,
// streaming write words in and read words out, with per-beat timeout and error abort.
module wb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_cmd_master_if.master  bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(SEL_W);
    localparam logic [ADDR_W-1:0] ADR_MASK = ~ADDR_W'(3);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WDAT, BUS, RESP, DONE, ERR} state_t;

    state_t           state;
    logic             we_q;
    logic [LEN_W-1:0] rem;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state            <= IDLE;
            we_q             <= 1'b0;
            rem              <= '0;
            cnt              <= '0;
            bus.cmd_ready_o  <= 1'b0;
            bus.wdat_ready_o <= 1'b0;
            bus.rdat_valid_o <= 1'b0;
            bus.rdat_o       <= '0;
            bus.wbm_cyc_o    <= 1'b0;
            bus.wbm_stb_o    <= 1'b0;
            bus.wbm_we_o     <= 1'b0;
            bus.wbm_sel_o    <= '0;
            bus.wbm_adr_o    <= '0;
            bus.wbm_dat_o    <= '0;
            bus.done_o       <= 1'b0;
            bus.err_o        <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            bus.err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready_o <= 1'b1;
                    if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                        bus.cmd_ready_o <= 1'b0;
                        bus.wbm_adr_o   <= bus.cmd_adr_i & ADR_MASK;
                        rem             <= bus.cmd_len_i;
                        we_q            <= bus.cmd_we_i;
                        if (bus.cmd_len_i == '0) begin
                            state <= DONE;
                        end else if (bus.cmd_we_i) begin
                            bus.wbm_cyc_o    <= 1'b1;
                            bus.wdat_ready_o <= 1'b1;
                            state            <= WDAT;
                        end else begin
                            bus.wbm_cyc_o <= 1'b1;
                            bus.wbm_stb_o <= 1'b1;
                            bus.wbm_sel_o <= '1;
                            bus.wbm_we_o  <= 1'b0;
                            cnt           <= '0;
                            state         <= BUS;
                        end
                    end
                end
                WDAT: begin
                    if (bus.wdat_valid_i && bus.wdat_ready_o) begin
                        bus.wbm_dat_o    <= bus.wdat_i;
                        bus.wdat_ready_o <= 1'b0;
                        bus.wbm_stb_o    <= 1'b1;
                        bus.wbm_sel_o    <= '1;
                        bus.wbm_we_o     <= 1'b1;
                        cnt              <= '0;
                        state            <= BUS;
                    end
                end
                BUS: begin
                    // A bus error wins over an ack seen in the same cycle.
                    if (bus.wbm_err_i || (!bus.wbm_ack_i && cnt == TO_LAST)) begin
                        bus.wbm_stb_o <= 1'b0;
                        bus.wbm_sel_o <= '0;
                        bus.wbm_we_o  <= 1'b0;
                        bus.wbm_cyc_o <= 1'b0;
                        state         <= ERR;
                    end else if (bus.wbm_ack_i) begin
                        bus.wbm_stb_o <= 1'b0;
                        bus.wbm_sel_o <= '0;
                        bus.wbm_we_o  <= 1'b0;
                        if (we_q) begin
                            bus.wbm_adr_o <= bus.wbm_adr_o + STEP;
                            rem           <= rem - LEN_W'(1);
                            if (rem == LEN_W'(1)) begin
                                bus.wbm_cyc_o <= 1'b0;
                                state         <= DONE;
                            end else begin
                                bus.wdat_ready_o <= 1'b1;
                                state            <= WDAT;
                            end
                        end else begin
                            bus.rdat_o       <= bus.wbm_dat_i;
                            bus.rdat_valid_o <= 1'b1;
                            state            <= RESP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rdat_ready_i && bus.rdat_valid_o) begin
                        bus.rdat_valid_o <= 1'b0;
                        bus.wbm_adr_o    <= bus.wbm_adr_o + STEP;
                        rem              <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            bus.wbm_cyc_o <= 1'b0;
                            state         <= DONE;
                        end else begin
                            bus.wbm_stb_o <= 1'b1;
                            bus.wbm_sel_o <= '1;
                            bus.wbm_we_o  <= 1'b0;
                            cnt           <= '0;
                            state         <= BUS;
                        end
                    end
                end
                DONE: begin
                    bus.done_o <= 1'b1;
                    state      <= IDLE;
                end
                ERR: begin
                    bus.err_o <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: stimulus pushes expected beats and read words into
// queues, a negedge monitor pops and compares them as the DUT presents them.
module tb_wb_cmd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_cmd_master_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();

    wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .TIMEOUT(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    logic [31:0] rd_q[$];
    logic [31:0] wdat_q[$];
    int          stb_runs[$];

    int checks = 0;
    int failures = 0;
    int ecount = 0;
    int hs_cyc = 0;

    // slave behaviour: 0 = ack on cycle ack_on, 1 = never respond, 2 = ack+err on ack_on
    int mode = 0;
    int ack_on = 1;
    int stall_word = -1;
    int stall_len = 0;

    // monitor-owned observations
    int beats = 0, n_done = 0, n_err = 0, cyc_falls = 0, stalls = 0, rv_cycles = 0;
    int stb_run = 0, last_stb_fall = 0, last_cyc_fall = 0, last_done_cyc = 0;
    logic prev_cyc = 1'b0, prev_done = 1'b0, prev_err = 1'b0, prev_end = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) ecount++;

    // Wishbone slave model
    int wait_n = 0;
    always begin
        logic hit;
        @(posedge clk); #2;
        if (bus.wbm_stb_o === 1'b1 && !rst) begin
            wait_n++;
            hit = (mode != 1) && (wait_n == ack_on);
            bus.wbm_ack_i = hit;
            bus.wbm_err_i = hit && (mode == 2);
            if (hit && !bus.wbm_we_o && rd_q.size() > 0) bus.wbm_dat_i = rd_q.pop_front();
        end else begin
            wait_n = 0;
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            if (bus.wbm_dat_i === 'x) bus.wbm_dat_i = '0;
        end
    end

    // write-word source
    logic wd_hs = 1'b0;
    always begin
        @(posedge clk); #1;
        if (wd_hs && wdat_q.size() > 0) void'(wdat_q.pop_front());
        bus.wdat_valid_i = (wdat_q.size() > 0);
        bus.wdat_i = (wdat_q.size() > 0) ? wdat_q[0] : 32'h0;
        wd_hs = bus.wdat_valid_i && (bus.wdat_ready_o === 1'b1);
    end

    // read-word sink with optional stall on one word
    logic rd_hs = 1'b0;
    int rd_idx = 0, stall_cnt = 0;
    always begin
        logic stall;
        @(posedge clk); #1;
        if (bus.wbm_cyc_o !== 1'b1) begin
            rd_idx = 0;
            stall_cnt = 0;
        end else if (rd_hs) begin
            rd_idx++;
        end
        stall = (bus.rdat_valid_o === 1'b1) && (rd_idx == stall_word) && (stall_cnt < stall_len);
        if (stall) stall_cnt++;
        bus.rdat_ready_i = !stall;
        rd_hs = (bus.rdat_valid_o === 1'b1) && !stall;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            stb_run = 0;
            prev_cyc = 1'b0;
            prev_done = 1'b0;
            prev_err = 1'b0;
            prev_end = 1'b0;
        end else begin
            if (bus.wbm_stb_o) begin
                stb_run++;
                chk("stb_inside_cyc", bus.wbm_cyc_o, 1'b1);
                if (bus.wbm_ack_i || bus.wbm_err_i) begin
                    beats++;
                    chk("beat_expected", exp_beats.size() > 0, 1'b1);
                    if (exp_beats.size() > 0) begin
                        beat_t b;
                        b = exp_beats.pop_front();
                        chk("beat_adr", bus.wbm_adr_o, b.adr);
                        chk("beat_we", bus.wbm_we_o, b.we);
                        chk("beat_sel", bus.wbm_sel_o, 4'hF);
                        if (b.we) chk("beat_dat", bus.wbm_dat_o, b.dat);
                    end
                end
            end else if (stb_run != 0) begin
                stb_runs.push_back(stb_run);
                last_stb_fall = ecount;
                stb_run = 0;
            end
            if (prev_cyc && !bus.wbm_cyc_o) begin
                cyc_falls++;
                last_cyc_fall = ecount;
            end
            prev_cyc = bus.wbm_cyc_o;
            if (bus.rdat_valid_o) begin
                rv_cycles++;
                chk("rdat_expected", exp_rd.size() > 0, 1'b1);
                if (exp_rd.size() > 0) begin
                    chk("rdat_value", bus.rdat_o, exp_rd[0]);
                    if (bus.rdat_ready_i) void'(exp_rd.pop_front());
                    else stalls++;
                end
            end
            if (prev_end) chk("ready_after_end", bus.cmd_ready_o, 1'b1);
            if (bus.done_o) begin
                n_done++;
                last_done_cyc = ecount;
                chk("done_single_cycle", prev_done, 1'b0);
                chk("done_cyc_low", bus.wbm_cyc_o, 1'b0);
            end
            if (bus.err_o) begin
                n_err++;
                chk("err_single_cycle", prev_err, 1'b0);
                chk("err_cyc_low", bus.wbm_cyc_o, 1'b0);
            end
            prev_done = bus.done_o;
            prev_err = bus.err_o;
            prev_end = bus.done_o || bus.err_o;
        end
    end

    function automatic logic [127:0] all_outs();
        return {bus.cmd_ready_o, bus.wdat_ready_o, bus.rdat_valid_o, bus.wbm_cyc_o,
                bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
                bus.wbm_dat_o, bus.rdat_o, bus.done_o, bus.err_o};
    endfunction

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
        int n = 0;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i = we;
        bus.cmd_adr_i = adr;
        bus.cmd_len_i = len;
        while (bus.cmd_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_accepted_in_time", n < 50, 1'b1);
        hs_cyc = ecount;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0);
        int n = 0;
        while (n_done + n_err == d0 + e0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("burst_end_in_time", n < 300, 1'b1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int d0, e0, b0, r0, c0, s0, v0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i = 1'b0;
        bus.cmd_adr_i = '0;
        bus.cmd_len_i = '0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_cmd_ready", bus.cmd_ready_o, 1'b1);

        // single write, slave acks on the 2nd stb cycle
        d0 = n_done; e0 = n_err; r0 = stb_runs.size();
        mode = 0; ack_on = 2;
        wdat_q.push_back(32'hDEADBEEF);
        exp_beats.push_back('{32'h3000_0004, 1'b1, 32'hDEADBEEF});
        send_cmd(1'b1, 32'h3000_0006, 8'd1);
        wait_end(d0, e0);
        chk("wr1_done", n_done, d0 + 1);
        chk("wr1_no_err", n_err, e0);
        chk("wr1_beats_left", exp_beats.size(), 0);
        chk("wr1_stb_pulses", stb_runs.size(), r0 + 1);
        chk("wr1_stb_len", stb_runs[stb_runs.size()-1], 2);

        // read burst with a 2-cycle stall on the 2nd word
        d0 = n_done; e0 = n_err; c0 = cyc_falls; s0 = stalls;
        ack_on = 1; stall_word = 1; stall_len = 2;
        rd_q = '{32'h11, 32'h22, 32'h33};
        exp_rd = '{32'h11, 32'h22, 32'h33};
        exp_beats.push_back('{32'h3000_0000, 1'b0, 32'h0});
        exp_beats.push_back('{32'h3000_0004, 1'b0, 32'h0});
        exp_beats.push_back('{32'h3000_0008, 1'b0, 32'h0});
        send_cmd(1'b0, 32'h3000_0000, 8'd3);
        wait_end(d0, e0);
        chk("rd3_done", n_done, d0 + 1);
        chk("rd3_no_err", n_err, e0);
        chk("rd3_words_left", exp_rd.size(), 0);
        chk("rd3_beats_left", exp_beats.size(), 0);
        chk("rd3_cyc_continuous", cyc_falls, c0 + 1);
        chk("rd3_stall_cycles", stalls, s0 + 2);
        stall_word = -1; stall_len = 0;

        // timeout: slave never answers
        d0 = n_done; e0 = n_err; b0 = beats; v0 = rv_cycles;
        mode = 1;
        send_cmd(1'b0, 32'h3000_0200, 8'd2);
        wait_end(d0, e0);
        chk("to_err", n_err, e0 + 1);
        chk("to_no_done", n_done, d0);
        chk("to_no_beat", beats, b0);
        chk("to_stb_len", stb_runs[stb_runs.size()-1], 4);
        chk("to_cyc_drop_with_stb", last_cyc_fall, last_stb_fall);
        chk("to_no_rdat", rv_cycles, v0);

        // ack and err together on the first write beat
        d0 = n_done; e0 = n_err; b0 = beats;
        mode = 2; ack_on = 1;
        wdat_q.push_back(32'hA5A5_0001);
        wdat_q.push_back(32'hA5A5_0002);
        exp_beats.push_back('{32'h3000_0300, 1'b1, 32'hA5A5_0001});
        send_cmd(1'b1, 32'h3000_0300, 8'd2);
        wait_end(d0, e0);
        chk("ep_err", n_err, e0 + 1);
        chk("ep_no_done", n_done, d0);
        chk("ep_one_beat", beats, b0 + 1);
        wdat_q.delete();
        mode = 0;
        repeat (2) @(posedge clk);

        // zero-length command
        d0 = n_done; e0 = n_err; c0 = cyc_falls; r0 = stb_runs.size();
        send_cmd(1'b1, 32'h3000_0400, 8'd0);
        wait_end(d0, e0);
        chk("z_done", n_done, d0 + 1);
        chk("z_done_latency", last_done_cyc - hs_cyc, 2);
        chk("z_no_cyc", cyc_falls, c0);
        chk("z_no_stb", stb_runs.size(), r0);

        // reset after the 2nd ack of a 4-word read, then a fresh write
        d0 = n_done; e0 = n_err; b0 = beats;
        rd_q = '{32'h101, 32'h102, 32'h103, 32'h104};
        exp_rd = '{32'h101, 32'h102};
        exp_beats.push_back('{32'h3000_0500, 1'b0, 32'h0});
        exp_beats.push_back('{32'h3000_0504, 1'b0, 32'h0});
        send_cmd(1'b0, 32'h3000_0500, 8'd4);
        begin
            int n = 0;
            while (beats < b0 + 2 && n < 100) begin
                @(posedge clk);
                n++;
            end
            chk("rst_second_ack_seen", n < 100, 1'b1);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_outputs", all_outs(), 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_q.delete();
        exp_rd.delete();
        chk("rst_beats_consumed", exp_beats.size(), 0);
        exp_beats.delete();
        d0 = n_done; e0 = n_err;
        wdat_q.push_back(32'hC0DE_0001);
        wdat_q.push_back(32'hC0DE_0002);
        exp_beats.push_back('{32'h3000_0600, 1'b1, 32'hC0DE_0001});
        exp_beats.push_back('{32'h3000_0604, 1'b1, 32'hC0DE_0002});
        send_cmd(1'b1, 32'h3000_0600, 8'd2);
        wait_end(d0, e0);
        chk("post_rst_done", n_done, d0 + 1);
        chk("post_rst_no_err", n_err, e0);
        chk("post_rst_beats_left", exp_beats.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=%0d required=<200000", $time);
        $fatal(1);
    end
endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic initiator for the matrix-multiply user area: the master end of the bus the user project exposes as a slave.
- Accepts word-burst commands (address, length, direction) on a valid/ready port.
- Streams write data in from, or read data out to, the matrix engine.
- Issues one single-beat Wishbone cycle per word, with per-beat timeout and bus-error abort.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, data width; byte lanes = DATA_W/8.
- LEN_W, 8, width of the command word count.
- TIMEOUT, 255, maximum cycles stb may wait for ack/err before abort; must be ≥1.

Ports:
- wb_clk_i in 1: clock.
- wb_rst_i in 1: synchronous reset, active-high.
- cmd_valid_i in 1: command offered.
- cmd_ready_o out 1: command accepted when high together with cmd_valid_i.
- cmd_we_i in 1: 1 = write burst, 0 = read burst.
- cmd_adr_i in ADDR_W: start byte address; bits [1:0] ignored and driven as 0.
- cmd_len_i in LEN_W: number of words to transfer.
- wdat_valid_i in 1: write word available.
- wdat_i in DATA_W: write word.
- wdat_ready_o out 1: write word consumed.
- rdat_valid_o out 1: read word presented.
- rdat_o out DATA_W: read word.
- rdat_ready_i in 1: read word consumed.
- wbm_cyc_o out 1: bus cycle.
- wbm_stb_o out 1: strobe.
- wbm_we_o out 1: write enable.
- wbm_sel_o out DATA_W/8: byte selects, all ones during stb, else 0.
- wbm_adr_o out ADDR_W: address.
- wbm_dat_o out DATA_W: write data.
- wbm_dat_i in DATA_W: read data.
- wbm_ack_i in 1: acknowledge.
- wbm_err_i in 1: bus error.
- done_o out 1: one-cycle pulse on successful burst completion.
- err_o out 1: one-cycle pulse on abort (bus error or timeout).

Behaviour:
- Reset: the following are 0 and state is IDLE at the first clock edge with wb_rst_i high, including mid-burst:
  - outputs: cmd_ready_o, wdat_ready_o, rdat_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rdat_o, done_o, err_o;
  - internal counters.
- All outputs are registered.
- States: IDLE, WDAT, BUS, RESP, DONE, ERR.
- IDLE:
  - cmd_ready_o=1.
  - On handshake, latch adr (with [1:0]=0), len and we.
  - len=0 → DONE. Else if we → WDAT, else → BUS.
- WDAT:
  - wbm_cyc_o held 1 (cyc stays high from first beat to DONE/ERR).
  - wdat_ready_o=1 in WDAT.
  - On wdat_valid_i, latch wdat_i into wbm_dat_o → BUS.
- BUS:
  - wbm_stb_o=1, wbm_sel_o all ones, wbm_we_o=latched we. Timeout counter increments each BUS cycle.
  - wbm_err_i → ERR. err has priority over a simultaneous ack.
  - Else, wbm_ack_i on a write:
    - stb drops the next cycle; adr += DATA_W/8; remaining−1.
    - remaining hits 0 → DONE, else → WDAT.
  - Else, wbm_ack_i on a read:
    - Latch wbm_dat_i into rdat_o → RESP.
  - Else, counter reaches TIMEOUT with no ack/err → ERR.
  - The counter clears on every BUS entry.
- RESP:
  - rdat_valid_o=1 and rdat_o held stable until rdat_ready_i. cyc stays 1, stb 0.
  - On handshake: adr += DATA_W/8; remaining−1; remaining 0 → DONE, else → BUS.
- DONE: cyc=stb=0; done_o=1 for exactly one cycle → IDLE.
- ERR: cyc=stb=0; err_o=1 for exactly one cycle; the rest of the burst is discarded → IDLE.
- Latency:
  - Write beat, zero-wait slave: 1 cycle WDAT (data present) + 1 cycle BUS.
  - Read beat, zero-wait slave and rdat_ready_i high: 1 cycle BUS + 1 cycle RESP.
- Address wraps modulo 2^ADDR_W with no error.
- wbm_ack_i or wbm_err_i while stb=0 is ignored.
- cmd_valid_i outside IDLE is ignored; no queuing.

Test Plan:
- Single write: cmd we=1, adr=0x3000_0004, len=1, wdat=0xDEADBEEF, slave acks on 2nd stb cycle → one stb pulse with adr 0x3000_0004, dat 0xDEADBEEF, sel=0xF; done_o one cycle; cmd_ready_o back to 1 the cycle after done.
- Read burst with backpressure: cmd we=0, adr=0x3000_0000, len=3; slave returns 0x11, 0x22, 0x33; rdat_ready_i low 2 cycles on the 2nd word → rdat_o sequence 0x11, 0x22, 0x33; adrs 0x0, 0x4, 0x8; rdat_o stable while stalled; cyc continuous across the burst; single done_o.
- Timeout: TIMEOUT=4, read len=2, slave never responds → stb high exactly 4 cycles; err_o pulse; cyc=0 next; no rdat_valid_o; done_o never asserted.
- Error priority: write len=2, ack and err asserted together on beat 1 → err_o pulse; no second beat; no done_o.
- Zero length: cmd len=0 → no cyc/stb ever; done_o pulse 2 cycles after handshake.
- Reset mid-burst: read len=4, wb_rst_i high after 2nd ack → all outputs 0 at that edge; new write cmd after release completes normally; adr starts from the new command.
